ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 90 +++++++++
 tb/tb_ifetch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch unit: issues one memory request at a time, holds the
// returned word for decode, and redirects (or faults) on branch/jump targets.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_FAULT
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_instr;
  logic        r_fault;
  logic        w_redir, w_redir_ok, w_redir_bad;

  // FAULT is terminal, so redirects there are ignored entirely
  assign w_redir     = redirect_valid && (r_state != S_FAULT);
  assign w_redir_bad = w_redir && (redirect_pc[1:0] != 2'b00);
  assign w_redir_ok  = w_redir && (redirect_pc[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_redir_bad) w_next = S_FAULT;
    else begin
      case (r_state)
        S_IDLE:  w_next = S_REQ;
        S_REQ: begin
          if (w_redir_ok)          w_next = imem_req_ready ? S_DRAIN : S_REQ;
          else if (imem_req_ready) w_next = S_WAIT;
        end
        S_WAIT: begin
          if (w_redir_ok)          w_next = imem_rsp_valid ? S_REQ : S_DRAIN;
          else if (imem_rsp_valid) w_next = S_HOLD;
        end
        S_HOLD:  if (w_redir_ok || instr_ready) w_next = S_REQ;
        // a stale request is in flight; swallow its response before refetching
        S_DRAIN: if (imem_rsp_valid) w_next = S_REQ;
        S_FAULT: w_next = S_FAULT;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0013;
      r_fault <= 1'b0;
    end else begin
      if (w_redir)
        r_pc <= redirect_pc;
      else if (r_state == S_HOLD && instr_ready)
        r_pc <= r_pc + 32'd4;
      if (r_state == S_WAIT && imem_rsp_valid && !w_redir)
        r_instr <= imem_rdata;
      if (w_redir_bad)
        r_fault <= 1'b1;
    end
  end

  always_comb begin
    imem_req_valid = (r_state == S_REQ);
    instr_valid    = (r_state == S_HOLD);
    imem_addr      = r_pc;
    pc             = r_pc;
    instr          = r_instr;
    fault          = r_fault;
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus a randomized run scored against
// a program-order PC model and an address-derived memory image.
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_rsp_valid;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic        req_valid2, instr_valid2, fault2;
  logic [31:0] addr2, instr2, pc2;

  ifetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fault(fault));

  // same inputs as u_dut, so it runs in lockstep but from the top of memory
  ifetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready), .imem_addr(addr2),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid2), .instr_ready(instr_ready), .instr(instr2), .pc(pc2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fault(fault2));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_cons = 0;
  int rdy_pct = 100, mem_lat = 0;
  bit mem_const_en = 1'b1, force_rsp = 1'b0, sb_en = 1'b0;
  logic [31:0] mem_const = 32'h0050_0013;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[15:0] ^ 16'hC3A5};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: single outstanding request, response mem_lat cycles after WAIT starts
  initial begin : mem_model
    bit fired = 0, outst = 0;
    int cnt = 0;
    logic [31:0] maddr = '0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      imem_rsp_valid = 1'b0;
      if (rst) begin
        fired = 0; outst = 0; imem_req_ready = 1'b0;
      end else begin
        if (fired) begin
          outst = 1; fired = 0;
          cnt = (mem_lat < 0) ? int'($urandom_range(3)) : mem_lat;
        end
        if (outst) begin
          if (cnt == 0) begin
            imem_rsp_valid = 1'b1; outst = 0;
            imem_rdata = mem_const_en ? mem_const : mem_fn(maddr);
          end else cnt--;
        end
        if (force_rsp) begin imem_rsp_valid = 1'b1; imem_rdata = 32'hBAD0_0BAD; end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        fired = imem_req_valid && imem_req_ready;
        if (fired) maddr = imem_addr;
      end
    end
  end

  // scoreboard monitor: every consumed instruction is the next in program order
  initial begin : monitor
    bit p_hold = 0;
    logic [31:0] p_pc = '0, p_instr = '0, e;
    forever begin
      @(negedge clk); #3;
      if (sb_en && !rst) begin
        check("excl req/instr", {31'd0, imem_req_valid && instr_valid}, 0);
        if (p_hold) begin
          check("hold valid", {31'd0, instr_valid}, 1);
          check("hold pc", pc, p_pc);
          check("hold instr", instr, p_instr);
        end
        if (!redirect_valid && instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            check("sb underflow", 0, 1);
          end else begin
            e = exp_q.pop_front();
            exp_q.push_back(exp_q.size() ? exp_q[$] + 32'd4 : e + 32'd4);
            check("sb pc", pc, e);
            check("sb instr", instr, mem_fn(e));
            n_cons++;
          end
        end
        p_hold = instr_valid && !instr_ready && !redirect_valid;
        p_pc = pc; p_instr = instr;
      end else p_hold = 0;
    end
  end

  task automatic fill_q(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // callers sit at negedge+2; the current cycle is examined first
  task automatic wait_fire(input string name, output logic [31:0] a);
    bit ok = 0;
    a = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (imem_req_valid && imem_req_ready) begin ok = 1; a = imem_addr; end
      else begin @(negedge clk); #2; end
    end
    check({name, " fire timeout"}, {31'd0, ok}, 1);
  endtask

  task automatic wait_hold(input string name);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (instr_valid) ok = 1;
      else begin @(negedge clk); #2; end
    end
    check({name, " hold timeout"}, {31'd0, ok}, 1);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0;
    #1;
    if (chk) begin
      check("rst req_valid", {31'd0, imem_req_valid}, 0);
      check("rst instr_valid", {31'd0, instr_valid}, 0);
      check("rst pc", pc, 32'h0);
      check("rst instr", instr, 32'h0000_0013);
      check("rst fault", {31'd0, fault}, 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
  endtask

  initial begin : main
    logic [31:0] a, fa[$], fa2[$];
    int fc[$];
    bit seen, bad, saw_rsp, saw_iv;
    logic [31:0] h_pc, h_instr;
    instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // zero-wait fetch stream from reset
    do_reset(1);
    check("idle after release", {31'd0, imem_req_valid}, 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #2;
      if (imem_req_valid && imem_req_ready) begin
        fa.push_back(imem_addr); fa2.push_back(addr2); fc.push_back(c);
      end
      if (instr_valid && !seen) begin
        seen = 1;
        check("first instr", instr, 32'h0050_0013);
        check("first pc", pc, 32'h0);
        check("dut2 first pc", pc2, 32'hFFFF_FFFC);
        check("dut2 first instr", instr2, 32'h0050_0013);
      end
    end
    if (fa.size() < 3 || fa2.size() < 2) check("fetch count", fa.size(), 3);
    else begin
      check("first req cycle", fc[0], 0);
      check("addr0", fa[0], 32'h0);
      check("addr1", fa[1], 32'h4);
      check("addr2", fa[2], 32'h8);
      check("throughput", fc[1] - fc[0], 3);
      check("wrap addr0", fa2[0], 32'hFFFF_FFFC);
      check("wrap addr1", fa2[1], 32'h0);
    end

    // decode stall holds everything steady and issues nothing
    instr_ready = 1'b0;
    wait_hold("stall");
    h_pc = pc; h_instr = instr; bad = 0;
    repeat (5) begin
      @(negedge clk); #2;
      if (!instr_valid || pc !== h_pc || instr !== h_instr || imem_req_valid) bad = 1;
    end
    check("stall stable", {31'd0, bad}, 0);
    instr_ready = 1'b1;

    // redirect while waiting on memory: late word dropped
    do_reset(0);
    mem_lat = 2; mem_const = 32'hDEAD_BEEF;
    wait_fire("wait-redir", a);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    saw_rsp = 0; saw_iv = 0;
    for (int i = 0; i < 20 && !imem_req_valid; i++) begin
      if (imem_rsp_valid) saw_rsp = 1;
      if (instr_valid) saw_iv = 1;
      @(negedge clk); #2;
    end
    check("drain saw rsp", {31'd0, saw_rsp}, 1);
    check("drain no instr", {31'd0, saw_iv}, 0);
    check("drain next addr", imem_addr, 32'h0000_0100);
    wait_hold("after drain");
    check("drain hold pc", pc, 32'h0000_0100);
    check("drain hold instr", instr, 32'hDEAD_BEEF);

    // misaligned redirect faults until reset
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("fault set", {31'd0, fault}, 1);
    check("fault pc", pc, 32'h0000_0102);
    bad = 0;
    repeat (10) begin
      @(negedge clk); #2;
      if (imem_req_valid || instr_valid || !fault) bad = 1;
    end
    check("fault quiet", {31'd0, bad}, 0);
    mem_lat = 0; mem_const = 32'h0050_0013;
    do_reset(1);
    wait_fire("post-fault", a);
    check("post-fault addr", a, 32'h0);

    // redirect in HOLD beats a concurrent instr_ready
    instr_ready = 1'b0;
    wait_hold("hold-redir");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("hold redir drop", {31'd0, instr_valid}, 0);
    wait_fire("hold-redir", a);
    check("hold redir addr", a, 32'h0000_0040);
    wait_hold("hold-redir2");
    check("hold redir pc", pc, 32'h0000_0040);

    // unsolicited responses outside WAIT are ignored
    do_reset(0);
    rdy_pct = 0; force_rsp = 1'b1; bad = 0;
    repeat (4) begin
      @(negedge clk); #2;
      if (instr_valid) bad = 1;
    end
    check("stray rsp ignored", {31'd0, bad}, 0);
    force_rsp = 1'b0; rdy_pct = 100;
    wait_hold("after stray");
    check("after stray instr", instr, 32'h0050_0013);
    check("after stray pc", pc, 32'h0);

    // randomized run against the program-order model
    do_reset(0);
    mem_const_en = 1'b0; mem_lat = -1; rdy_pct = 60;
    fill_q(32'h0);
    sb_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      instr_ready = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(99) < 6);
      redirect_pc = 32'($urandom_range(1023)) << 2;
      if (redirect_valid) fill_q(redirect_pc);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    sb_en = 1'b0;
    check("random consumed >= 50", {31'd0, n_cons >= 50}, 1);
    check("lockstep valid", {30'd0, instr_valid2, fault2}, {30'd0, instr_valid, fault});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
